// File: rtl/spi_frame_sequencer_if.sv
// Bus bundle between the SPI frame sequencer and its surroundings.
// Ports: cs_n/mosi/rd_data into the sequencer; miso, miso_oe, rd_addr,
// wr_addr, wr_data, wr_toggle, busy and addr_err out of it.
interface spi_frame_sequencer_if;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_toggle;
    logic       busy;
    logic       addr_err;

    modport slave (
        input  cs_n, mosi, rd_data,
        output miso, miso_oe, rd_addr, wr_addr, wr_data,
        output wr_toggle, busy, addr_err
    );

    modport master (
        output cs_n, mosi, rd_data,
        input  miso, miso_oe, rd_addr, wr_addr, wr_data,
        input  wr_toggle, busy, addr_err
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// SPI register frame sequencer in the sclk domain: command decode, read
// turnaround, burst auto-increment and toggle-published writes.
// Ports: sclk, rst_n (async, active-low), bus (slave modport: cs_n, mosi,
// rd_data in; miso, miso_oe, rd_addr, wr_addr, wr_data, wr_toggle, busy,
// addr_err out).
module spi_frame_sequencer #(
    parameter int NUM_REGS    = 4,
    parameter int DUMMY_BYTES = 1
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    spi_frame_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        DUMMY,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       burst;
    logic [1:0] dcnt;
    logic       miso_q;
    logic       oe_q;
    logic       busy_q;

    logic [5:0] addr;
    logic [5:0] wa_q;
    logic [7:0] wd_q;
    logic       tog_q;
    logic       aerr_q;

    // Frame logic is also cleared whenever chip select is released.
    logic frm_rst_n;
    assign frm_rst_n = rst_n & ~bus.cs_n;

    logic       byte_done;
    logic [7:0] in_byte;
    logic       addr_ok;
    logic       cmd_ok;
    logic [5:0] addr_nxt;
    logic [7:0] ld_data;
    logic       last_dummy;
    logic       cmd_done;
    logic       dum_done;
    logic       rd_done;
    logic       wr_done;

    always_comb begin
        byte_done  = (bit_cnt == 3'd7);
        in_byte    = {shreg[6:0], bus.mosi};
        addr_ok    = ({1'b0, addr} < 7'(NUM_REGS));
        cmd_ok     = ({1'b0, in_byte[5:0]} < 7'(NUM_REGS));
        addr_nxt   = (addr >= 6'(NUM_REGS - 1)) ? 6'd0 : addr + 6'd1;
        // Out-of-range reads return zero rather than bank garbage.
        ld_data    = addr_ok ? bus.rd_data : 8'h00;
        last_dummy = (dcnt == 2'(DUMMY_BYTES - 1));
        cmd_done   = (state == IDLE)  && byte_done;
        dum_done   = (state == DUMMY) && byte_done && last_dummy;
        rd_done    = (state == READ)  && byte_done;
        wr_done    = (state == WRITE) && byte_done;
    end

    always_ff @(posedge sclk or negedge frm_rst_n) begin
        if (!frm_rst_n) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            burst   <= 1'b0;
            dcnt    <= 2'd0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            unique case (state)
                IDLE: begin
                    shreg <= in_byte;
                    if (byte_done) begin
                        burst  <= in_byte[6];
                        busy_q <= 1'b1;
                        dcnt   <= 2'd0;
                        state  <= in_byte[7] ? DUMMY : WRITE;
                    end
                end
                DUMMY: begin
                    if (byte_done) begin
                        if (last_dummy) begin
                            shreg  <= ld_data;
                            miso_q <= ld_data[7];
                            oe_q   <= 1'b1;
                            state  <= READ;
                        end else begin
                            dcnt <= dcnt + 2'd1;
                        end
                    end
                end
                READ: begin
                    if (byte_done) begin
                        shreg  <= ld_data;
                        miso_q <= ld_data[7];
                    end else begin
                        shreg  <= {shreg[6:0], 1'b0};
                        miso_q <= shreg[6];
                    end
                end
                WRITE: begin
                    shreg <= in_byte;
                end
            endcase
        end
    end

    // Address and write results survive chip-select release.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= 6'd0;
            wa_q   <= 6'd0;
            wd_q   <= 8'h00;
            tog_q  <= 1'b0;
            aerr_q <= 1'b0;
        end else if (!bus.cs_n) begin
            if (cmd_done) begin
                addr <= in_byte[5:0];
                if (!cmd_ok) aerr_q <= 1'b1;
            end
            if ((dum_done || rd_done) && burst) begin
                addr <= addr_nxt;
            end
            if (wr_done) begin
                if (addr_ok) begin
                    wd_q  <= in_byte;
                    wa_q  <= addr;
                    tog_q <= ~tog_q;
                end else begin
                    aerr_q <= 1'b1;
                end
                if (burst) addr <= addr_nxt;
            end
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = oe_q;
    assign bus.rd_addr   = addr;
    assign bus.wr_addr   = wa_q;
    assign bus.wr_data   = wd_q;
    assign bus.wr_toggle = tog_q;
    assign bus.busy      = busy_q;
    assign bus.addr_err  = aerr_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Self-checking bench for spi_frame_sequencer: an SPI master drives frames,
// write and read scoreboards hold the expected results.
module tb_spi_frame_sequencer;

    logic sclk;
    logic rst_n;

    spi_frame_sequencer_if bus ();

    spi_frame_sequencer #(
        .NUM_REGS    (4),
        .DUMMY_BYTES (1)
    ) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic [7:0] regs [4];
    initial begin
        regs[0] = 8'h96;
        regs[1] = 8'h01;
        regs[2] = 8'h02;
        regs[3] = 8'h03;
    end

    always_comb begin
        bus.rd_data = 8'hEE;
        if (bus.rd_addr < 6'd4) bus.rd_data = regs[bus.rd_addr[1:0]];
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [13:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    int          n_push = 0;

    task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        n_push++;
    endtask

    logic        tog_prev = 1'b0;
    logic        ign_tog  = 1'b0;
    logic [13:0] we;

    always @(negedge sclk) begin
        if (ign_tog || !rst_n) begin
            tog_prev = bus.wr_toggle;
        end else if (bus.wr_toggle !== tog_prev) begin
            tog_prev = bus.wr_toggle;
            chk("tog_expected", 32'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                we = exp_wr.pop_front();
                chk("wr_addr", bus.wr_addr, we[13:8]);
                chk("wr_data", bus.wr_data, we[7:0]);
            end
        end
    end

    logic [7:0] rx;
    logic       oa;
    logic       ol;
    logic [5:0] ra;

    task automatic spi_bits(input logic [7:0] tx, input int nb);
        rx = 8'h00;
        oa = 1'b0;
        ol = 1'b1;
        for (int i = 7; i >= 8 - nb; i--) begin
            @(negedge sclk);
            if (i == 7) ra = bus.rd_addr;
            rx[i]    = bus.miso;
            oa       = oa | bus.miso_oe;
            ol       = ol & bus.miso_oe;
            bus.cs_n = 1'b0;
            bus.mosi = tx[i];
        end
    endtask

    task automatic send(input logic [7:0] tx);
        spi_bits(tx, 8);
    endtask

    task automatic rd_byte(input string tag);
        logic [7:0] e;
        spi_bits(8'h00, 8);
        e = exp_rd.pop_front();
        chk(tag, rx, e);
        chk("oe_data", ol, 1);
    endtask

    task automatic dummy_byte();
        spi_bits(8'h00, 8);
        chk("dummy_miso", rx, 0);
        chk("dummy_oe", oa, 0);
    endtask

    task automatic end_frame(input logic exp_busy);
        @(negedge sclk);
        chk("busy", bus.busy, exp_busy);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        #1;
        chk("busy_clr", bus.busy, 0);
        chk("oe_clr", bus.miso_oe, 0);
        @(negedge sclk);
    endtask

    logic       tog_save;
    logic [5:0] ra_exp [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge sclk);
        chk("rst_miso", bus.miso, 0);
        chk("rst_oe", bus.miso_oe, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_tog", bus.wr_toggle, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_aerr", bus.addr_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        // single write
        push_wr(6'd1, 8'hA5);
        send(8'h01);
        send(8'hA5);
        end_frame(1'b1);
        chk("wq_empty1", exp_wr.size(), 0);
        chk("w1_aerr", bus.addr_err, 0);

        // single read of address 0
        send(8'h80);
        dummy_byte();
        exp_rd.push_back(8'h96);
        rd_byte("rd_single");
        chk("rd_addr0", ra, 0);
        end_frame(1'b1);

        // burst write wrapping 3 -> 0
        push_wr(6'd3, 8'h11);
        push_wr(6'd0, 8'h22);
        send(8'h43);
        send(8'h11);
        send(8'h22);
        end_frame(1'b1);
        chk("wq_empty2", exp_wr.size(), 0);

        // burst read from 2 with wrap
        ra_exp[0] = 6'd2;
        ra_exp[1] = 6'd3;
        ra_exp[2] = 6'd0;
        ra_exp[3] = 6'd1;
        exp_rd.push_back(8'h02);
        exp_rd.push_back(8'h03);
        exp_rd.push_back(8'h96);
        send(8'hC2);
        dummy_byte();
        chk("brd_addr0", ra, ra_exp[0]);
        for (int k = 1; k < 4; k++) begin
            rd_byte("rd_burst");
            chk("brd_addr", ra, ra_exp[k]);
        end
        end_frame(1'b1);

        // out-of-range write then read
        tog_save = bus.wr_toggle;
        send(8'h05);
        send(8'hFF);
        end_frame(1'b1);
        chk("oor_tog", bus.wr_toggle, tog_save);
        chk("oor_aerr", bus.addr_err, 1);
        exp_rd.push_back(8'h00);
        send(8'h85);
        dummy_byte();
        rd_byte("rd_oor");
        end_frame(1'b1);
        chk("oor_aerr2", bus.addr_err, 1);

        // abort mid data byte
        tog_save = bus.wr_toggle;
        send(8'h02);
        spi_bits(8'h5A, 4);
        end_frame(1'b1);
        chk("abort_tog", bus.wr_toggle, tog_save);
        push_wr(6'd2, 8'h3C);
        send(8'h02);
        send(8'h3C);
        end_frame(1'b1);
        push_wr(6'd3, 8'h77);
        send(8'h03);
        send(8'h77);
        end_frame(1'b1);
        chk("wq_empty3", exp_wr.size(), 0);
        chk("tog_parity", bus.wr_toggle, n_push[0]);
        chk("aerr_sticky", bus.addr_err, 1);

        // reset while reading
        send(8'h80);
        dummy_byte();
        @(negedge sclk);
        chk("pre_rst_miso", bus.miso, 1);
        chk("pre_rst_oe", bus.miso_oe, 1);
        ign_tog = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("arst_miso", bus.miso, 0);
        chk("arst_oe", bus.miso_oe, 0);
        chk("arst_tog", bus.wr_toggle, 0);
        chk("arst_aerr", bus.addr_err, 0);
        chk("arst_busy", bus.busy, 0);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        #10;
        rst_n = 1'b1;
        @(negedge sclk);
        ign_tog = 1'b0;
        @(negedge sclk);

        // normal decode after reset
        push_wr(6'd1, 8'h5A);
        send(8'h01);
        send(8'h5A);
        end_frame(1'b1);
        chk("wq_empty4", exp_wr.size(), 0);
        chk("post_tog", bus.wr_toggle, 1);
        chk("rq_empty", exp_rd.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
